// File: rtl/stripe_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stripe_seq_ctrl                                                 |
// | Purpose  : Symbol sequencer for a 4-lane byte striper. Frames upstream      |
// |            packets with STP/END, nullifies broken or over-long packets     |
// |            with EDB, pads frames to a lane boundary with IDL, inserts      |
// |            periodic SKP ordered sets and fills idle time with IDL.         |
// | Ports    : clk, reset_l      - symbol clock, async active-low reset        |
// |            en                - enable, sampled in IDLE at a lane boundary  |
// |            in_data/in_valid/in_last/in_ready - upstream byte handshake     |
// |            d, dk, d_valid    - registered symbol to the striper            |
// |            slot              - registered target lane of d (0..3)         |
// |            skp_busy          - high while an SKP ordered set is on d       |
// |            nullified         - pulse coincident with an EDB on d           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module stripe_seq_ctrl #(
   parameter int SKP_INTERVAL = 1180,
   parameter int MAX_LEN      = 256
) (
   input  logic       clk,
   input  logic       reset_l,
   input  logic       en,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [7:0] d,
   output logic       dk,
   output logic       d_valid,
   output logic [1:0] slot,
   output logic       skp_busy,
   output logic       nullified
);

   localparam logic [7:0]  c_sym_stp  = 8'hfb;
   localparam logic [7:0]  c_sym_end  = 8'hfd;
   localparam logic [7:0]  c_sym_edb  = 8'hfe;
   localparam logic [7:0]  c_sym_com  = 8'hbc;
   localparam logic [7:0]  c_sym_skp  = 8'h1c;
   localparam logic [7:0]  c_sym_idl  = 8'h7c;

   localparam logic [9:0]  c_max_len  = 10'(MAX_LEN);
   localparam logic [10:0] c_skp_term = 11'(SKP_INTERVAL - 1);

   // The STP symbol is emitted on the IDLE->DATA transition edge itself so
   // that it lands on slot 0; a separate STP state would push it to slot 1.
   localparam logic [2:0]  c_st_idle  = 3'd0;
   localparam logic [2:0]  c_st_data  = 3'd1;
   localparam logic [2:0]  c_st_end   = 3'd2;
   localparam logic [2:0]  c_st_edb   = 3'd3;
   localparam logic [2:0]  c_st_pad   = 3'd4;
   localparam logic [2:0]  c_st_skp   = 3'd5;

   logic [2:0]  r_state;
   logic [9:0]  r_cnt;
   logic [3:0]  r_skp_idx;
   logic [10:0] r_skp_cnt;
   logic        r_skp_pending;

   logic [2:0]  w_state_nxt;
   logic [9:0]  w_cnt_nxt;
   logic [9:0]  w_cnt_inc;
   logic [3:0]  w_idx_nxt;
   logic [7:0]  w_d;
   logic        w_dk;
   logic        w_valid;
   logic        w_nul;
   logic        w_busy;
   logic        w_skp_take;
   logic        w_skp_term;
   logic        w_boundary;
   logic        w_lands_last;

   assign in_ready     = (r_state == c_st_data);
   assign w_boundary   = (slot == 2'd3);
   // A valid symbol emitted now lands on slot 3 when the current slot is 2.
   assign w_lands_last = (slot == 2'd2);
   assign w_cnt_inc    = r_cnt + 10'd1;
   assign w_skp_term   = (r_skp_cnt == c_skp_term);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_skp_idx;
      w_d         = c_sym_idl;
      w_dk        = 1'b1;
      w_valid     = 1'b1;
      w_nul       = 1'b0;
      w_busy      = 1'b0;
      w_skp_take  = 1'b0;
      case (r_state)
         c_st_idle: begin
            if (w_boundary) begin
               // SKP only goes out while enabled; a held request waits for en.
               if (en && r_skp_pending) begin
                  w_d         = c_sym_com;
                  w_busy      = 1'b1;
                  w_idx_nxt   = 4'd1;
                  w_skp_take  = 1'b1;
                  w_state_nxt = c_st_skp;
               end else if (en && in_valid) begin
                  w_d         = c_sym_stp;
                  w_cnt_nxt   = 10'd0;
                  w_state_nxt = c_st_data;
               end else begin
                  w_valid     = en;
               end
            end
         end
         c_st_data: begin
            if (in_valid) begin
               w_d       = in_data;
               w_dk      = 1'b0;
               w_cnt_nxt = w_cnt_inc;
               if (in_last) begin
                  w_state_nxt = c_st_end;
               end else if (w_cnt_inc == c_max_len) begin
                  w_state_nxt = c_st_edb;
               end
            end else begin
               // Source starved mid-packet: nullify right away.
               w_d         = c_sym_edb;
               w_nul       = 1'b1;
               w_state_nxt = w_lands_last ? c_st_idle : c_st_pad;
            end
         end
         c_st_end: begin
            w_d         = c_sym_end;
            w_state_nxt = w_lands_last ? c_st_idle : c_st_pad;
         end
         c_st_edb: begin
            w_d         = c_sym_edb;
            w_nul       = 1'b1;
            w_state_nxt = w_lands_last ? c_st_idle : c_st_pad;
         end
         c_st_pad: begin
            if (w_lands_last) begin
               w_state_nxt = c_st_idle;
            end
         end
         c_st_skp: begin
            // Symbols 0-3 carry COM so each lane sees COM first.
            w_d       = (r_skp_idx < 4'd4) ? c_sym_com : c_sym_skp;
            w_busy    = 1'b1;
            w_idx_nxt = r_skp_idx + 4'd1;
            if (r_skp_idx == 4'd15) begin
               w_state_nxt = c_st_idle;
            end
         end
         default: begin
            w_state_nxt = c_st_idle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_state       <= c_st_idle;
         r_cnt         <= 10'd0;
         r_skp_idx     <= 4'd0;
         r_skp_cnt     <= 11'd0;
         r_skp_pending <= 1'b0;
         d             <= c_sym_idl;
         dk            <= 1'b1;
         d_valid       <= 1'b0;
         slot          <= 2'd3;
         skp_busy      <= 1'b0;
         nullified     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_skp_idx     <= w_idx_nxt;
         r_skp_cnt     <= w_skp_term ? 11'd0 : r_skp_cnt + 11'd1;
         // A new request on the entry edge must survive the clear.
         r_skp_pending <= w_skp_term | (r_skp_pending & ~w_skp_take);
         d             <= w_d;
         dk            <= w_dk;
         d_valid       <= w_valid;
         slot          <= w_valid ? slot + 2'd1 : slot;
         skp_busy      <= w_busy;
         nullified     <= w_nul;
      end
   end

endmodule
`default_nettype wire

// File: doc/stripe_seq_ctrl.md
Name: stripe_seq_ctrl

Overview:
- Sequencer that feeds the 4-lane byte striper one symbol per clock.
- Frames packets from an upstream byte source with STP/END, nullifies broken packets with EDB, and pads each frame to a 4-symbol lane boundary with IDL.
- Schedules periodic SKP ordered sets between packets, and emits IDL when no traffic is present.
- Drives the striper's D/DK inputs plus a lane-slot index so the four striped lanes stay symbol-aligned.

Parameters:
- SKP_INTERVAL, 1180, cycles between SKP requests (counter terminal count); legal range 20..2047.
- MAX_LEN, 256, maximum payload bytes per packet before forced nullify; legal range 1..1023.

Ports:
- CLK  in  1  symbol clock; all state on rising edge.
- RESET_L  in  1  asynchronous, active-low reset.
- EN  in  1  sequencer enable; sampled only in IDLE at a lane boundary.
- IN_DATA  in  8  payload byte.
- IN_VALID  in  1  IN_DATA valid.
- IN_LAST  in  1  IN_DATA is last byte of packet.
- IN_READY  out  1  byte accepted on an edge where IN_VALID & IN_READY.
- D  out  8  symbol to striper (registered).
- DK  out  1  1 = D is a K-symbol (registered).
- D_VALID  out  1  D/DK valid this cycle (registered).
- SLOT  out  2  target lane (0..3) of current D (registered).
- SKP_BUSY  out  1  high while the SKP ordered set is being emitted (registered).
- NULLIFIED  out  1  one-cycle pulse coincident with an EDB on D.

Behaviour:
- Reset values (async on RESET_L low):
  - D=8'h7c (IDL), DK=1, D_VALID=0, SLOT=3, SKP_BUSY=0, NULLIFIED=0.
  - state=IDLE, SKP counter=0, skp_pending=0, byte count=0.
- Symbol codes (K unless noted): STP 8'hfb, END 8'hfd, EDB 8'hfe, COM 8'hbc, SKP 8'h1c, IDL 8'h7c; payload DK=0.
- Output timing:
  - All outputs except IN_READY update on the rising edge from current state and inputs.
  - A byte accepted at edge k is on D during cycle k..k+1.
  - IN_READY = (state==DATA), decoded from state only; there is no combinational path from inputs.
- SLOT rules:
  - SLOT increments mod 4 on every edge that loads D_VALID=1.
  - "Boundary" means the next symbol lands on SLOT 0, i.e. current SLOT==3.
- States:
  - IDLE: emit IDL, D_VALID=EN. At a boundary, priority is: skp_pending -> SKP; else EN & IN_VALID -> STP; else EN=0 -> D_VALID=0, SLOT held at 3.
  - STP: emit STP on SLOT 0 -> DATA; byte count cleared.
  - DATA: if IN_VALID, emit IN_DATA and count+1.
    - IN_LAST -> END.
    - Else count==MAX_LEN -> EDB.
    - Else stay in DATA.
  - DATA with IN_VALID=0: emit EDB immediately, pulse NULLIFIED, -> PAD (or IDLE if emitted on SLOT 3).
  - END: emit END -> PAD, or IDLE if END lands on SLOT 3.
  - EDB: emit EDB, pulse NULLIFIED -> PAD, or IDLE if on SLOT 3.
  - PAD: emit IDL until the SLOT 3 symbol is emitted -> IDLE.
  - SKP: 16 symbols, SKP_BUSY=1 throughout, starting on SLOT 0.
    - Symbols 0-3 are COM; symbols 4-15 are SKP.
    - Each lane therefore receives COM,SKP,SKP,SKP.
    - Then -> IDLE.
- SKP scheduling:
  - Free-running counter increments every cycle out of reset.
  - At SKP_INTERVAL-1 it sets skp_pending and wraps to 0.
  - skp_pending clears on SKP entry.
  - A request arriving during a packet, PAD or SKP is held until the next IDLE boundary; it is never dropped.
  - A second request while pending is merged into the first.
- EN deassert takes effect only at an IDLE boundary. Frames and SKP in progress always complete.
- EN low does not stop the SKP counter; pending requests are served when EN returns.
- Every frame (STP..END/EDB+PAD) and every SKP set occupies a whole multiple of 4 symbols.
- Reset mid-frame: outputs return to reset values immediately. No END/EDB is emitted, and the upstream byte in flight is not accepted.

Test Plan:
- Reset, EN=1, no traffic -> D_VALID rises on the first edge after release. D=7c DK=1 repeats, with SLOT cycling 0,1,2,3.
- 5-byte packet 11..15 with IN_LAST on 15 -> D = FB,11,12,13,14,15,FD,7C on SLOT 0..3,0..3. IN_READY high for exactly 5 cycles.
- 2-byte packet AA,BB -> FB,AA,BB,FD. END on SLOT 3, no PAD, next symbol IDL on SLOT 0.
- IN_VALID drops after 2 bytes of a packet -> FB,b0,b1,FE(K),7C... with NULLIFIED one pulse on the FE cycle.
- MAX_LEN=3, 6-byte packet -> FB,b0,b1,b2,FE, then IDL to a boundary; IN_READY low after b2. Remaining source bytes start a new STP only when IN_VALID is presented at the next IDLE boundary.
- SKP_INTERVAL=20 with request raised mid-packet -> SKP deferred until after END/PAD. Then 4×BC, 12×1C (all K) starting on SLOT 0 with SKP_BUSY high for 16 cycles, then IDL or a pending packet.
